// File: rtl/i2c_rx_fifo_writer_if.sv
// FIFO write-port bundle between the I2C RX byte writer and the RX FIFO.
// master: the byte writer (drives data/push, observes the fill flags).
// slave : the FIFO write side.
interface i2c_rx_fifo_writer_if;
  logic [7:0] w_data;
  logic       w_enable;
  logic       full;
  logic       almost_full;

  modport master (
    output w_data,
    output w_enable,
    input  full,
    input  almost_full
  );

  modport slave (
    input  w_data,
    input  w_enable,
    output full,
    output almost_full
  );
endinterface

// File: rtl/i2c_rx_fifo_writer.sv
// I2C RX FIFO writer: assembles MSB-first bytes from synchronized SCL-rise
// strobes, drives the ACK bit and pushes completed bytes into the RX FIFO
// through a one-entry holding register.
//
// Optional feature macro: I2C_RX_NACK_ON_FULL_EN
//   defined   : a byte arriving while the FIFO is full/almost-full or the hold
//               register is occupied is dropped and NACKed; overrun stays 0.
//   undefined : every completed byte is ACKed; a byte arriving with the hold
//               register occupied is dropped and sets the sticky overrun flag.
module i2c_rx_fifo_writer #(
  parameter int COUNT_W = 8
) (
  input  logic                   w_clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   scl_rise,
  input  logic                   sda_in,
  input  logic                   start_det,
  input  logic                   stop_det,
  i2c_rx_fifo_writer_if.master   fifo,
  output logic                   ack_out,
  output logic                   busy,
  output logic                   overrun,
  output logic [COUNT_W-1:0]     byte_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t               state_q;
  logic [2:0]           bit_cnt_q;
  // Only the first seven bits are stored; the eighth comes straight from sda_in.
  logic [6:0]           shreg_q;
  logic [7:0]           hold_q;
  logic                 hold_valid_q;
  logic                 ack_q;
  logic                 overrun_q;
  logic [7:0]           w_data_q;
  logic                 w_enable_q;
  logic [COUNT_W-1:0]   byte_count_q;

  logic                 push_go;
  logic                 byte_done;
  logic                 hold_free;
  logic                 byte_accept;
  logic                 ack_on_done;
  logic                 overrun_set;
  logic [7:0]           byte_d;

  // Push engine decision, completed-byte detection and acceptance policy.
  always_comb begin
    // A push needs a held byte, room in the FIFO and no push last cycle,
    // which keeps w_enable pulses at least two cycles apart.
    push_go   = hold_valid_q & ~fifo.full & ~w_enable_q;
    // Start/stop take priority over a coincident sample, so they suppress it.
    byte_done = (state_q == SHIFT) & scl_rise & ~start_det & ~stop_det &
                (bit_cnt_q == 3'd7);
    byte_d    = {shreg_q, sda_in};
    // The hold register frees up on the same edge it is pushed out.
    hold_free = ~hold_valid_q | push_go;
`ifdef I2C_RX_NACK_ON_FULL_EN
    byte_accept = byte_done & hold_free & ~fifo.full & ~fifo.almost_full;
    ack_on_done = byte_accept;
    overrun_set = 1'b0;
`else
    byte_accept = byte_done & hold_free;
    ack_on_done = 1'b1;
    overrun_set = byte_done & ~hold_free;
`endif
  end

`ifndef I2C_RX_NACK_ON_FULL_EN
  // almost_full only matters when NACK-on-full is built in.
  logic unused_almost_full;
  assign unused_almost_full = fifo.almost_full;
`endif

  // Bit-level FSM plus holding register and sticky overrun flag.
  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 7'd0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (clear) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 7'd0;
      hold_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // Hold register: a new byte wins over the push that empties it.
      if (byte_accept) begin
        hold_q       <= byte_d;
        hold_valid_q <= 1'b1;
      end else if (push_go) begin
        hold_valid_q <= 1'b0;
      end

      if (overrun_set) begin
        overrun_q <= 1'b1;
      end

      if (stop_det) begin
        // STOP ends the transfer; any partial byte is discarded.
        state_q   <= IDLE;
        bit_cnt_q <= 3'd0;
        ack_q     <= 1'b0;
      end else if (start_det) begin
        // START or repeated START restarts byte assembly.
        state_q   <= SHIFT;
        bit_cnt_q <= 3'd0;
        shreg_q   <= 7'd0;
        ack_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          SHIFT: begin
            if (scl_rise) begin
              shreg_q   <= byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= ACK;
                ack_q   <= ack_on_done;
              end
            end
          end
          ACK: begin
            // The ninth SCL clock closes the ACK slot.
            if (scl_rise) begin
              state_q   <= SHIFT;
              bit_cnt_q <= 3'd0;
              ack_q     <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // FIFO write port: registered one-cycle push strobe, data and push counter.
  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      w_data_q     <= 8'd0;
      w_enable_q   <= 1'b0;
      byte_count_q <= '0;
    end else if (clear) begin
      // w_data is deliberately left as-is.
      w_enable_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      w_enable_q <= push_go;
      if (push_go) begin
        w_data_q     <= hold_q;
        byte_count_q <= byte_count_q + 1'b1;
      end
    end
  end

  assign fifo.w_data   = w_data_q;
  assign fifo.w_enable = w_enable_q;
  assign ack_out       = ack_q;
  assign busy          = (state_q != IDLE);
  assign overrun       = overrun_q;
  assign byte_count    = byte_count_q;

endmodule

// File: tb/tb_i2c_rx_fifo_writer.sv
// Directed self-checking bench for i2c_rx_fifo_writer.
// Expectations follow the build: I2C_RX_NACK_ON_FULL_EN selects the NACK policy.
module tb_i2c_rx_fifo_writer;

  logic       w_clk = 1'b0;
  logic       n_rst;
  logic       clear;
  logic       scl_rise;
  logic       sda_in;
  logic       start_det;
  logic       stop_det;
  logic       ack_out;
  logic       busy;
  logic       overrun;
  logic [7:0] byte_count;

  i2c_rx_fifo_writer_if fifo_if ();

  i2c_rx_fifo_writer #(.COUNT_W(8)) dut (
    .w_clk      (w_clk),
    .n_rst      (n_rst),
    .clear      (clear),
    .scl_rise   (scl_rise),
    .sda_in     (sda_in),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .fifo       (fifo_if),
    .ack_out    (ack_out),
    .busy       (busy),
    .overrun    (overrun),
    .byte_count (byte_count)
  );

  always #5 w_clk = ~w_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Push monitor: records every pushed byte and counts back-to-back pushes.
  logic [7:0] pushed[$];
  bit         prev_we = 1'b0;
  int         b2b     = 0;

  always @(negedge w_clk) begin
    if (fifo_if.w_enable === 1'b1) begin
      pushed.push_back(fifo_if.w_data);
      if (prev_we) b2b++;
    end
    prev_we = (fifo_if.w_enable === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge w_clk);
      #1;
    end
  endtask

  logic last_ack;

  task automatic strobe_start();
    start_det = 1'b1;
    step(1);
    start_det = 1'b0;
    step(3);
  endtask

  task automatic strobe_stop();
    stop_det = 1'b1;
    step(1);
    stop_det = 1'b0;
    step(3);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);
  endtask

  // One SCL rising strobe followed by the minimum 4-cycle spacing.
  task automatic send_bit(input logic b);
    sda_in   = b;
    scl_rise = 1'b1;
    step(1);
    scl_rise = 1'b0;
    last_ack = ack_out;
    step(3);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    $display("byte %02h sent, ack_out=%0b", v, last_ack);
  endtask

  task automatic ack_clk();
    send_bit(1'b0);
  endtask

`ifdef I2C_RX_NACK_ON_FULL_EN
  localparam logic EXP_ACK_FULL = 1'b0;
  localparam logic EXP_OVR_FULL = 1'b0;
  localparam int   EXP_REL_PUSH = 0;
  localparam int   EXP_CNT_T3   = 3;
  localparam logic EXP_ACK_AF   = 1'b0;
  localparam int   EXP_AF_PUSH  = 0;
`else
  localparam logic EXP_ACK_FULL = 1'b1;
  localparam logic EXP_OVR_FULL = 1'b1;
  localparam int   EXP_REL_PUSH = 1;
  localparam int   EXP_CNT_T3   = 4;
  localparam logic EXP_ACK_AF   = 1'b1;
  localparam int   EXP_AF_PUSH  = 1;
`endif

  initial begin
    logic [7:0] v;
    int base;

    n_rst = 1'b0; clear = 1'b0; scl_rise = 1'b0; sda_in = 1'b0;
    start_det = 1'b0; stop_det = 1'b0;
    fifo_if.full = 1'b0; fifo_if.almost_full = 1'b0;

    // ---- reset state ----
    step(3);
    chk("rst_we",    fifo_if.w_enable, 0);
    chk("rst_wdata", fifo_if.w_data,   0);
    chk("rst_ack",   ack_out,    0);
    chk("rst_busy",  busy,       0);
    chk("rst_ovr",   overrun,    0);
    chk("rst_cnt",   byte_count, 0);
    n_rst = 1'b1;
    step(1);

    // ---- byte 0xA5 with cycle-exact push timing ----
    strobe_start();
    chk("t1_busy", busy, 1);
    v = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    sda_in = v[0]; scl_rise = 1'b1;
    step(1);
    scl_rise = 1'b0;
    chk("t1_ack_N",  ack_out, 1);
    chk("t1_we_N",   fifo_if.w_enable, 0);
    step(1);
    chk("t1_we_N1",  fifo_if.w_enable, 1);
    chk("t1_wd_N1",  fifo_if.w_data, 8'hA5);
    chk("t1_cnt",    byte_count, 1);
    step(1);
    chk("t1_we_N2",  fifo_if.w_enable, 0);
    chk("t1_wd_N2",  fifo_if.w_data, 8'hA5);
    step(1);
    ack_clk();
    chk("t1_ack_clr", last_ack, 0);
    chk("t1_busy2",   busy, 1);
    $display("byte a5 pushed, byte_count=%0d", byte_count);

    // ---- three back-to-back bytes ----
    pulse_clear();
    chk("t2_clr_cnt",  byte_count, 0);
    chk("t2_clr_busy", busy, 0);
    base = pushed.size();
    strobe_start();
    for (int k = 1; k <= 3; k++) begin
      v = 8'(k);
      send_byte(v);
      chk("t2_ack", last_ack, 1);
      ack_clk();
    end
    step(4);
    chk("t2_npush", pushed.size() - base, 3);
    chk("t2_b0",    pushed[base],     8'h01);
    chk("t2_b1",    pushed[base + 1], 8'h02);
    chk("t2_b2",    pushed[base + 2], 8'h03);
    chk("t2_cnt",   byte_count, 3);
    chk("t2_ovr",   overrun, 0);

    // ---- FIFO full: first byte held, second dropped ----
    fifo_if.full = 1'b1;
    base = pushed.size();
    send_byte(8'h11);
    chk("t3_ack11", last_ack, EXP_ACK_FULL);
    ack_clk();
    send_byte(8'h22);
    chk("t3_ack22", last_ack, EXP_ACK_FULL);
    ack_clk();
    step(4);
    chk("t3_nopush", pushed.size() - base, 0);
    chk("t3_ovr",    overrun, EXP_OVR_FULL);
    fifo_if.full = 1'b0;
    step(6);
    chk("t3_relpush", pushed.size() - base, EXP_REL_PUSH);
`ifndef I2C_RX_NACK_ON_FULL_EN
    chk("t3_reldata", pushed[base], 8'h11);
`endif
    chk("t3_cnt", byte_count, EXP_CNT_T3);

    // ---- almost_full during a byte ----
    pulse_clear();
    chk("t4_clr_ovr", overrun, 0);
    fifo_if.almost_full = 1'b1;
    strobe_start();
    base = pushed.size();
    send_byte(8'h33);
    chk("t4_ack", last_ack, EXP_ACK_AF);
    ack_clk();
    step(4);
    chk("t4_npush", pushed.size() - base, EXP_AF_PUSH);
    chk("t4_ovr",   overrun, 0);
    chk("t4_cnt",   byte_count, EXP_AF_PUSH);
    fifo_if.almost_full = 1'b0;

    // ---- repeated START mid-byte, then STOP mid-byte ----
    base = pushed.size();
    strobe_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    strobe_start();
    send_byte(8'hC3);
    chk("t5_ack", last_ack, 1);
    ack_clk();
    step(4);
    chk("t5_npush", pushed.size() - base, 1);
    chk("t5_data",  pushed[base], 8'hC3);
    chk("t5_cnt",   byte_count, EXP_AF_PUSH + 1);
    for (int k = 0; k < 5; k++) send_bit(1'b1);
    chk("t5_busy_mid", busy, 1);
    strobe_stop();
    chk("t5_busy_stop", busy, 0);
    step(4);
    chk("t5_nopush", pushed.size() - base, 1);
    chk("t5_cnt2",   byte_count, EXP_AF_PUSH + 1);
    $display("stop after 5 bits, busy=%0b", busy);

    // ---- clear while a byte waits behind full ----
    fifo_if.full = 1'b1;
    base = pushed.size();
    strobe_start();
    send_byte(8'h5A);
    ack_clk();
    step(2);
    pulse_clear();
    fifo_if.full = 1'b0;
    step(10);
    chk("t6_nopush", pushed.size() - base, 0);
    chk("t6_ovr",    overrun, 0);
    chk("t6_cnt",    byte_count, 0);
    chk("t6_busy",   busy, 0);
    chk("t6_ack",    ack_out, 0);
    chk("t6_wdata",  fifo_if.w_data, 8'hC3);

    chk("push_spacing", b2b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_rx_fifo_writer.md
# i2c_rx_fifo_writer

Write-side companion of the I2C RX byte FIFO. Deserializes bits from the I2C receive path (SCL rising-edge strobes already synchronized into `w_clk`), assembles MSB-first bytes, drives the ACK bit, and pushes each completed byte into the FIFO through its `w_enable`/`w_data` port using a one-entry holding register. Lives in the I2C register block between the bit-level SDA/SCL front end and the RX FIFO.

## Interface

Parameters:
- COUNT_W, 8, width of `byte_count` (bytes successfully pushed).

Ports:
- w_clk  in  1  system clock, shared with the FIFO write side.
- n_rst  in  1  reset n_rst, asynchronous, active-low.
- clear  in  1  synchronous soft clear; overrides all other inputs.
- scl_rise  in  1  one-cycle strobe: SCL rising edge, sample `sda_in`.
- sda_in  in  1  synchronized SDA level.
- start_det  in  1  one-cycle strobe: START or repeated START detected.
- stop_det  in  1  one-cycle strobe: STOP detected.
- full  in  1  FIFO full flag.
- almost_full  in  1  FIFO almost-full flag.
- w_data  out  8  byte to FIFO; registered.
- w_enable  out  1  FIFO push strobe; registered, one cycle wide.
- ack_out  out  1  1 = pull SDA low during ACK bit.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky: byte dropped because holding register occupied.
- byte_count  out  COUNT_W  bytes pushed, wraps modulo 2^COUNT_W.

## Operation

- States: IDLE, SHIFT, ACK.
- IDLE: `start_det` -> SHIFT, bit_cnt=0, shreg=0. `scl_rise` ignored.
- SHIFT: on `scl_rise`, shreg <= {shreg[6:0], sda_in}, bit_cnt++. On the 8th sample -> ACK; completed byte {shreg[6:0], sda_in} is accepted into hold if hold empty, else dropped and `overrun` set.
- ACK: `ack_out`=1 iff the byte was accepted (see Configuration). Next `scl_rise` (9th clock) -> SHIFT, bit_cnt=0, `ack_out`<=0.
- `stop_det` in any state -> IDLE, partial byte discarded, `ack_out`<=0; hold and any pending push are kept.
- `start_det` in SHIFT/ACK (repeated START) -> SHIFT, bit_cnt=0, partial byte discarded, `ack_out`<=0.
- Simultaneous `start_det` and `stop_det`: `stop_det` wins.
- Push engine: when hold_valid and !full and no push in the previous cycle, w_data<=hold, w_enable<=1, hold_valid<=0, byte_count++. While `full`, hold waits indefinitely.
- A byte completing on the same edge hold is emptied by a push is accepted (no overrun).
- `clear`: state->IDLE, hold_valid, overrun, byte_count, ack_out, w_enable <= 0; w_data unchanged.
- Reset: all outputs 0, state IDLE, hold empty.

## Timing

- 8th `scl_rise` sampled at edge N: hold_valid and `ack_out` set at N.
- If !full at N, `w_enable` high from edge N+1 to N+2; `w_data` valid from N+1 and stable until the next push (FIFO captures data the cycle after the pointer moves).
- Minimum push spacing: 2 cycles (w_enable never high in consecutive cycles).
- `ack_out` cleared at the edge sampling the 9th `scl_rise`.
- Upstream guarantees at least 4 `w_clk` cycles between `scl_rise` strobes. Behaviour below that rate is undefined.
- `overrun` and `byte_count` update on the same edge as the triggering event.

## Configuration

- `I2C_RX_NACK_ON_FULL_EN` defined: on the 8th bit, if `full` or `almost_full` is high, or hold is occupied, the byte is dropped, `ack_out`=0 (NACK), and `overrun` is NOT set (the master is informed instead).
- Not defined: `ack_out`=1 for every completed byte. Drops with hold occupied set `overrun`. `full`/`almost_full` affect only push timing.

## Test plan

- Reset, then START, bits 1,0,1,0,0,1,0,1, with FIFO empty -> `ack_out`=1 after the 8th bit; one `w_enable` pulse 1 cycle later with `w_data`=0xA5; `byte_count`=1.
- Three bytes 0x01, 0x02, 0x03 back-to-back, with `full`=0 -> three single-cycle pushes in order; `byte_count`=3; `overrun`=0.
- `full`=1 held, two bytes 0x11 then 0x22 (macro undefined) -> 0x11 held, 0x22 dropped, `overrun`=1. Release `full` -> single push of 0x11.
- Macro defined, `almost_full`=1, byte 0x33 -> `ack_out`=0, no push, `overrun`=0.
- START, 4 bits, then repeated START and byte 0xC3 -> only 0xC3 pushed. STOP after 5 bits -> IDLE, no push, `busy`=0.
- `clear` asserted while hold_valid with `full`=1 -> no later push; `overrun`=0, `byte_count`=0, state IDLE.
